// File: rtl/alu_stateful_v3.sv
// alu_stateful_v3: stateful ALU slot with a private data RAM, page-table based
// tenant isolation, RAM atomics and a hold-until-accepted result handshake.
// One transaction runs IDLE -> READ -> EXEC -> OUT; the RAM write lands in EXEC,
// before the next read can be issued, so no forwarding path is needed.
module alu_stateful_v3 #(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_ID  = 3,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ACTION_LEN-1:0]   action_in,
  input  logic                    action_valid,
  input  logic [DATA_WIDTH-1:0]   operand_1_in,
  input  logic [DATA_WIDTH-1:0]   operand_2_in,
  input  logic [DATA_WIDTH-1:0]   operand_3_in,
  output logic                    ready_out,
  input  logic [2*ADDR_WIDTH-1:0] page_tbl_out,
  input  logic                    page_tbl_out_valid,
  output logic [DATA_WIDTH-1:0]   container_out,
  output logic                    container_out_valid,
  output logic                    overflow_out,
  input  logic                    ready_in
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [3:0] OP_ADD    = 4'b0001;
  localparam logic [3:0] OP_ADDI   = 4'b1001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_SUBI   = 4'b1010;
  localparam logic [3:0] OP_AND    = 4'b0100;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_GE     = 4'b0110;
  localparam logic [3:0] OP_SET    = 4'b1110;
  localparam logic [3:0] OP_STORE  = 4'b1000;
  localparam logic [3:0] OP_LOAD   = 4'b1011;
  localparam logic [3:0] OP_LOADD  = 4'b0111;
  localparam logic [3:0] OP_FADD   = 4'b1100;
  localparam logic [3:0] OP_FMAX   = 4'b1101;
  localparam logic [3:0] OP_CLEAR  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state, state_next;

  // Transaction context captured at accept
  logic [3:0]            opcode;
  logic [DATA_WIDTH-1:0] op1, op2, op3;
  logic [ADDR_WIDTH-1:0] base_addr, addr_len;
  logic                  page_valid;

  // RAM and its registered read data
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;

  // Combinational execute results
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  stateful;
  logic                  denied;
  logic                  ovf;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] phys;

  // The informational parameters and the non-opcode action bits carry no logic
  logic unused_bits;
  assign unused_bits = ^{action_in[ACTION_LEN-5:0], STAGE_ID[0], ACTION_ID[0]};

  assign ready_out           = (state == IDLE);
  assign container_out_valid = (state == OUT);
  assign accept              = action_valid && (state == IDLE);

  // Offset comes from operand 2; the physical address wraps within the RAM
  assign off    = op2[ADDR_WIDTH-1:0];
  assign phys   = base_addr + off;
  assign denied = !page_valid || (off > addr_len);

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: fixed three-step walk, then hold in OUT until accepted
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (action_valid) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = OUT;
      OUT:     if (ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture opcode, operands and page entry on the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      opcode     <= action_in[ACTION_LEN-1:ACTION_LEN-4];
      op1        <= operand_1_in;
      op2        <= operand_2_in;
      op3        <= operand_3_in;
      addr_len   <= page_tbl_out[2*ADDR_WIDTH-1:ADDR_WIDTH];
      base_addr  <= page_tbl_out[ADDR_WIDTH-1:0];
      page_valid <= page_tbl_out_valid;
    end
  end

  // RAM: synchronous read in READ, single write in EXEC suppressed under reset
  always_ff @(posedge clk) begin
    if (rst_n && (state == EXEC) && wr_en) mem[phys] <= wr_data;
    if (state == READ) rd_data <= mem[phys];
  end

  // Execute: compute result and write-back; denied stateful ops pass op3 through
  always_comb begin
    result   = op3;
    wr_data  = '0;
    wr_en    = 1'b0;
    stateful = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI: result = op1 + op2;
      OP_SUB, OP_SUBI: result = op1 - op2;
      OP_AND:   result = {{(DATA_WIDTH-1){1'b0}}, (op1 != '0) && (op2 != '0)};
      OP_OR:    result = {{(DATA_WIDTH-1){1'b0}}, (op1 != '0) || (op2 != '0)};
      OP_GE:    result = {{(DATA_WIDTH-1){1'b0}}, op1 >= op2};
      OP_SET:   result = op2;
      OP_STORE: begin
        stateful = 1'b1;
        wr_en    = 1'b1;
        wr_data  = op1;
        result   = op3;
      end
      OP_LOAD: begin
        stateful = 1'b1;
        result   = rd_data;
      end
      OP_LOADD: begin
        stateful = 1'b1;
        wr_en    = 1'b1;
        wr_data  = rd_data + 1'b1;
        result   = rd_data + 1'b1;
      end
      OP_FADD: begin
        stateful = 1'b1;
        wr_en    = 1'b1;
        wr_data  = rd_data + op1;
        result   = rd_data + op1;
      end
      OP_FMAX: begin
        stateful = 1'b1;
        wr_en    = 1'b1;
        wr_data  = (rd_data > op1) ? rd_data : op1;
        result   = rd_data;
      end
      OP_CLEAR: begin
        stateful = 1'b1;
        wr_en    = 1'b1;
        wr_data  = '0;
        result   = rd_data;
      end
      default: result = op3;
    endcase
    ovf = stateful && denied;
    if (ovf) begin
      wr_en  = 1'b0;
      result = op3;
    end
  end

  // Register the result and overflow flag in EXEC; they stay stable through OUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      container_out <= '0;
      overflow_out  <= 1'b0;
    end else if (state == EXEC) begin
      container_out <= result;
      overflow_out  <= ovf;
    end
  end

endmodule
